pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter, instruction-register and processor-status-register block for the multicycle CPU. It sits directly upstream of the control FSM. It drives the instruction memory address, latches the fetched word into the instruction register that feeds the FSM, and holds the PSR flags the FSM consumes. It also applies the FSM's `pcEn`/`pcIncOrSet` commands, evaluating the jump/branch condition against the PSR.

## Interface

Parameters:

- `ADDR_WIDTH`, 16: PC and address width.
- `RESET_PC`, 0: PC value after reset.

Ports:

- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-low.
- `pcEn` in 1: PC update strobe from the FSM.
- `pcIncOrSet` in 1: 0 = increment, 1 = conditional set (JMP/Bcond).
- `irEn` in 1: load instruction register from `memData`.
- `psrEn` in 1: PSR update strobe from the FSM.
- `aluFlags` in 5: ALU flags {N,Z,F,L,C} as bits [4:0].
- `jumpTarget` in 16: Rtarget data from the register file.
- `memData` in 16: instruction memory read data (synchronous read of `pc`).
- `pc` out ADDR_WIDTH: current PC and instruction memory address.
- `instruction` out 16: instruction register contents, to the FSM.
- `psrFlags` out 5: PSR {N,Z,F,L,C}, to the FSM.
- `taken` out 1: combinational condition result for `instruction[11:8]`.

## Operation

- **Instruction register.** On `irEn=1`, `instruction <= memData`; otherwise hold.
- **Condition evaluation.** `cond = instruction[11:8]` selects the test that drives `taken`:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 HI: L
  - 5 LS: !L
  - 6 GT: N
  - 7 LE: !N
  - 8 FS: F
  - 9 FC: !F
  - A LO: !L&!Z
  - B HS: L|Z
  - C LT: !N&!Z
  - D GE: N|Z
  - E UC: 1
  - F: 0
- **PC update.** Applies only when `pcEn=1`, in priority order:
  - `pcIncOrSet=0`: `pc <= pc+1`.
  - `pcIncOrSet=1` and `taken=0`: `pc <= pc+1`.
  - `pcIncOrSet=1`, `taken=1`, `instruction[15:12]=4'b1100` (Bcond): `pc <= pc + sext(instruction[7:0])`.
  - `pcIncOrSet=1`, `taken=1`, any other opcode (Jcond): `pc <= jumpTarget[ADDR_WIDTH-1:0]`.
- **PC arithmetic.**
  - All PC arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
  - The sign-extended displacement is ADDR_WIDTH wide.
- **PSR update.** On `psrEn=1`, `psrFlags <= aluFlags` only if the current `instruction` is flag-setting:
  - ADDI (0101), SUBI (1001) or CMPI (1011) opcodes; or
  - Rtype (0000) with `instruction[7:4]` equal to 0101 ADD, 1001 SUB or 1011 CMP.
  - For all other instructions `psrFlags` holds, so JMP/LOAD/STORE/logic ops never clobber the flags.
- **Simultaneous events.**
  - All registers update independently in the same cycle.
  - The IR captures `memData`; the PC and PSR use the pre-edge `instruction` for decode and `taken`.
- **Reset.**
  - Reset has priority over every strobe. `reset=0` at a rising edge forces `pc=RESET_PC`, `instruction=16'h0000`, `psrFlags=5'b00000`.
  - Reset mid-instruction discards the in-flight PC update and flag update.

## Timing

- All state changes on the rising edge of `clock`. `taken` is combinational from `instruction` and `psrFlags`; no other combinational input-to-output paths exist.
- Reset values: `pc=RESET_PC`, `instruction=0`, `psrFlags=0`. `taken` then reads cond 0 (EQ), giving 0.
- Memory contract: `memData` is valid one cycle after `pc` changes. The FSM's IF→DECODE sequence provides exactly this, with `irEn` in the DECODE cycle.
- PC update latency: 1 cycle from `pcEn`. The new `pc` is visible at the next edge's output, so the following IF state fetches it.
- PSR latency: 1 cycle from `psrEn`. Flags written in EXECUTE are visible to the next instruction's `taken`.
- No handshake or backpressure: strobes are single-cycle commands and are never queued.

## Test plan

- **Reset.** Hold `reset=0` 2 cycles with all strobes high, `memData=16'hBEEF` -> `pc=0`, `instruction=0`, `psrFlags=0`. Release reset and pulse `pcEn` with `pcIncOrSet=0` -> `pc=1`.
- **Fetch and increment.**
  - Pulse `irEn` with `memData=16'h5103` -> `instruction=16'h5103` next cycle.
  - Pulse `pcEn` with `pcIncOrSet=0` from `pc=16'hFFFF` -> `pc=16'h0000` (wrap).
- **Jcond taken and not-taken.**
  - Set `instruction=16'h40C3` (EQ), `psrFlags` with Z=1, `jumpTarget=16'h0123`; pulse `pcEn`+`pcIncOrSet` -> `pc=16'h0123`.
  - Repeat with Z=0 from `pc=16'h0010` -> `pc=16'h0011`.
- **Bcond displacement.** `instruction=16'hCEFC` (UC, disp -4), `pc=16'h0010`; pulse `pcEn`+`pcIncOrSet` -> `pc=16'h000C`.
- **PSR gating.**
  - `instruction=16'hB105` (CMPI), `aluFlags=5'b01000`, `psrEn=1` -> `psrFlags=5'b01000`.
  - Then `instruction=16'h1105` (ANDI), `aluFlags=5'b10001`, `psrEn=1` -> `psrFlags` stays `5'b01000`.
- **Simultaneous strobes.** With `instruction=16'h41C2` (NE), Z=1, and `irEn`, `pcEn`, `pcIncOrSet` all high in one cycle with `memData=16'h0000` -> `pc=pc+1` (not taken on the old IR) and `instruction=16'h0000`.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// PC, instruction register and PSR for the multicycle CPU.
// Applies the FSM's pcEn/pcIncOrSet commands, evaluating Jcond/Bcond against the PSR.
module pc_fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pcEn,
  input  logic                  pcIncOrSet,
  input  logic                  irEn,
  input  logic                  psrEn,
  input  logic [4:0]            aluFlags,
  input  logic [15:0]           jumpTarget,
  input  logic [15:0]           memData,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [15:0]           instruction,
  output logic [4:0]            psrFlags,
  output logic                  taken
);

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_CMP   = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = 1;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           ir_q, ir_d;
  logic [4:0]            psr_q, psr_d;
  logic                  taken_c;
  logic                  flag_set_c;
  logic [ADDR_WIDTH-1:0] disp_c;
  logic                  n_f, z_f, f_f, l_f, c_f;

  assign {n_f, z_f, f_f, l_f, c_f} = psr_q;

  always_comb begin
    taken_c = 1'b0;
    case (ir_q[11:8])
      4'h0: taken_c = z_f;
      4'h1: taken_c = !z_f;
      4'h2: taken_c = c_f;
      4'h3: taken_c = !c_f;
      4'h4: taken_c = l_f;
      4'h5: taken_c = !l_f;
      4'h6: taken_c = n_f;
      4'h7: taken_c = !n_f;
      4'h8: taken_c = f_f;
      4'h9: taken_c = !f_f;
      4'hA: taken_c = !l_f && !z_f;
      4'hB: taken_c = l_f || z_f;
      4'hC: taken_c = !n_f && !z_f;
      4'hD: taken_c = n_f || z_f;
      4'hE: taken_c = 1'b1;
      default: taken_c = 1'b0;
    endcase
  end

  // Only add/sub/compare forms write the PSR; everything else must leave the flags alone.
  always_comb begin
    flag_set_c = 1'b0;
    case (ir_q[15:12])
      OP_ADD, OP_SUB, OP_CMP: flag_set_c = 1'b1;
      OP_RTYPE: flag_set_c = (ir_q[7:4] == OP_ADD) || (ir_q[7:4] == OP_SUB)
                             || (ir_q[7:4] == OP_CMP);
      default: flag_set_c = 1'b0;
    endcase
  end

  assign disp_c = {{(ADDR_WIDTH-8){ir_q[7]}}, ir_q[7:0]};

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    psr_d = psr_q;
    if (pcEn) begin
      if (pcIncOrSet && taken_c) begin
        if (ir_q[15:12] == OP_BCOND) pc_d = pc_q + disp_c;
        else                         pc_d = jumpTarget[ADDR_WIDTH-1:0];
      end else begin
        pc_d = pc_q + PC_ONE;
      end
    end
    if (irEn)                psr_d = psr_d;
    if (psrEn && flag_set_c) psr_d = aluFlags;
    if (irEn)                ir_d  = memData;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q  <= RESET_PC;
      ir_q  <= 16'h0000;
      psr_q <= 5'b00000;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      psr_q <= psr_d;
    end
  end

  assign pc          = pc_q;
  assign instruction = ir_q;
  assign psrFlags    = psr_q;
  assign taken       = taken_c;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, randomized run against a
// behavioural model, and a hand-written backward-branch wrap sequence.
module tb_pc_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        pcEn, pcIncOrSet, irEn, psrEn;
  logic [4:0]  aluFlags;
  logic [15:0] jumpTarget, memData;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic [4:0]  psrFlags;
  logic        taken;

  int vec_count = 0;
  int err_count = 0;

  pc_fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clock(clock), .reset(reset), .pcEn(pcEn), .pcIncOrSet(pcIncOrSet),
    .irEn(irEn), .psrEn(psrEn), .aluFlags(aluFlags), .jumpTarget(jumpTarget),
    .memData(memData), .pc(pc), .instruction(instruction), .psrFlags(psrFlags),
    .taken(taken)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n, pc_en, inc_set, ir_en, psr_en;
    logic [4:0]  alu;
    logic [15:0] jt, md;
    logic [15:0] e_pc, e_ir;
    logic [4:0]  e_psr;
    logic        e_tk;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst_n, logic pc_en, logic inc_set, logic ir_en,
                              logic psr_en, logic [4:0] alu, logic [15:0] jt,
                              logic [15:0] md, logic [15:0] e_pc, logic [15:0] e_ir,
                              logic [4:0] e_psr, logic e_tk);
    vec_t v;
    v.rst_n = rst_n; v.pc_en = pc_en; v.inc_set = inc_set; v.ir_en = ir_en;
    v.psr_en = psr_en; v.alu = alu; v.jt = jt; v.md = md;
    v.e_pc = e_pc; v.e_ir = e_ir; v.e_psr = e_psr; v.e_tk = e_tk;
    return v;
  endfunction

  // Behavioural reference state
  int       m_pc = 0;
  bit [15:0] m_ir = 0;
  bit [4:0]  m_psr = 0;

  function automatic bit cond_true(bit [3:0] c, bit [4:0] f);
    bit n = f[4], z = f[3], fl = f[2], l = f[1], cy = f[0];
    case (c)
      0: return z;          1: return !z;
      2: return cy;         3: return !cy;
      4: return l;          5: return !l;
      6: return n;          7: return !n;
      8: return fl;         9: return !fl;
      10: return !l && !z;  11: return l || z;
      12: return !n && !z;  13: return n || z;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit sets_flags(bit [15:0] ir);
    int op = ir[15:12];
    int fn = ir[7:4];
    if (op == 5 || op == 9 || op == 11) return 1'b1;
    if (op == 0 && (fn == 5 || fn == 9 || fn == 11)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_step(vec_t v);
    int disp;
    bit tk = cond_true(m_ir[11:8], m_psr);
    if (!v.rst_n) begin
      m_pc = 0; m_ir = 0; m_psr = 0;
      return;
    end
    if (v.pc_en) begin
      if (v.inc_set && tk) begin
        if (m_ir[15:12] == 4'hC) begin
          disp = m_ir[7] ? int'(m_ir[7:0]) - 256 : int'(m_ir[7:0]);
          m_pc = (m_pc + disp + 65536) % 65536;
        end else begin
          m_pc = int'(v.jt);
        end
      end else begin
        m_pc = (m_pc + 1) % 65536;
      end
    end
    if (v.psr_en && sets_flags(m_ir)) m_psr = v.alu;
    if (v.ir_en) m_ir = v.md;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    reset = v.rst_n; pcEn = v.pc_en; pcIncOrSet = v.inc_set; irEn = v.ir_en;
    psrEn = v.psr_en; aluFlags = v.alu; jumpTarget = v.jt; memData = v.md;
    model_step(v);
    @(posedge clock);
    #1;
  endtask

  task automatic check_table(string tag, vec_t v);
    chk({tag, ".pc"}, pc, v.e_pc);
    chk({tag, ".ir"}, instruction, v.e_ir);
    chk({tag, ".psr"}, {11'b0, psrFlags}, {11'b0, v.e_psr});
    chk({tag, ".taken"}, {15'b0, taken}, {15'b0, v.e_tk});
  endtask

  task automatic check_model(string tag);
    chk({tag, ".pc"}, pc, 16'(m_pc));
    chk({tag, ".ir"}, instruction, m_ir);
    chk({tag, ".psr"}, {11'b0, psrFlags}, {11'b0, m_psr});
    chk({tag, ".taken"}, {15'b0, taken}, {15'b0, cond_true(m_ir[11:8], m_psr)});
  endtask

  initial begin
    vec_t v;
    // rst_n pcEn set irEn psrEn alu jt md | pc ir psr taken
    tbl.push_back(mk(0,1,1,1,1,5'h1F,16'hFFFF,16'hBEEF, 16'h0000,16'h0000,5'h00,0));
    tbl.push_back(mk(0,1,1,1,1,5'h1F,16'hFFFF,16'hBEEF, 16'h0000,16'h0000,5'h00,0));
    tbl.push_back(mk(1,1,0,0,0,5'h00,16'h0000,16'h0000, 16'h0001,16'h0000,5'h00,0));
    tbl.push_back(mk(1,0,0,1,0,5'h00,16'h0000,16'h5103, 16'h0001,16'h5103,5'h00,1));
    tbl.push_back(mk(1,0,0,0,1,5'h08,16'h0000,16'h0000, 16'h0001,16'h5103,5'h08,0));
    tbl.push_back(mk(1,0,0,1,0,5'h00,16'h0000,16'h40C3, 16'h0001,16'h40C3,5'h08,1));
    tbl.push_back(mk(1,1,1,0,0,5'h00,16'h0123,16'h0000, 16'h0123,16'h40C3,5'h08,1));
    tbl.push_back(mk(1,0,0,1,0,5'h00,16'h0000,16'hB000, 16'h0123,16'hB000,5'h08,1));
    tbl.push_back(mk(1,0,0,0,1,5'h00,16'h0000,16'h0000, 16'h0123,16'hB000,5'h00,0));
    tbl.push_back(mk(1,0,0,1,0,5'h00,16'h0000,16'h0E00, 16'h0123,16'h0E00,5'h00,1));
    tbl.push_back(mk(1,1,1,0,0,5'h00,16'h0010,16'h0000, 16'h0010,16'h0E00,5'h00,1));
    tbl.push_back(mk(1,0,0,1,0,5'h00,16'h0000,16'h40C3, 16'h0010,16'h40C3,5'h00,0));
    tbl.push_back(mk(1,1,1,0,0,5'h00,16'h0123,16'h0000, 16'h0011,16'h40C3,5'h00,0));
    tbl.push_back(mk(1,0,0,1,0,5'h00,16'h0000,16'h0E00, 16'h0011,16'h0E00,5'h00,1));
    tbl.push_back(mk(1,1,1,0,0,5'h00,16'h0010,16'h0000, 16'h0010,16'h0E00,5'h00,1));
    tbl.push_back(mk(1,0,0,1,0,5'h00,16'h0000,16'hCEFC, 16'h0010,16'hCEFC,5'h00,1));
    tbl.push_back(mk(1,1,1,0,0,5'h00,16'h0999,16'h0000, 16'h000C,16'hCEFC,5'h00,1));
    tbl.push_back(mk(1,0,0,1,0,5'h00,16'h0000,16'h0E00, 16'h000C,16'h0E00,5'h00,1));
    tbl.push_back(mk(1,1,1,0,0,5'h00,16'hFFFF,16'h0000, 16'hFFFF,16'h0E00,5'h00,1));
    tbl.push_back(mk(1,1,0,0,0,5'h00,16'h0000,16'h0000, 16'h0000,16'h0E00,5'h00,1));
    tbl.push_back(mk(1,0,0,1,0,5'h00,16'h0000,16'hB105, 16'h0000,16'hB105,5'h00,1));
    tbl.push_back(mk(1,0,0,0,1,5'h08,16'h0000,16'h0000, 16'h0000,16'hB105,5'h08,0));
    tbl.push_back(mk(1,0,0,1,0,5'h00,16'h0000,16'h1105, 16'h0000,16'h1105,5'h08,0));
    tbl.push_back(mk(1,0,0,0,1,5'h11,16'h0000,16'h0000, 16'h0000,16'h1105,5'h08,0));
    tbl.push_back(mk(1,0,0,1,0,5'h00,16'h0000,16'h0E50, 16'h0000,16'h0E50,5'h08,1));
    tbl.push_back(mk(1,0,0,0,1,5'h11,16'h0000,16'h0000, 16'h0000,16'h0E50,5'h11,1));
    tbl.push_back(mk(1,0,0,1,0,5'h00,16'h0000,16'h0E10, 16'h0000,16'h0E10,5'h11,1));
    tbl.push_back(mk(1,0,0,0,1,5'h04,16'h0000,16'h0000, 16'h0000,16'h0E10,5'h11,1));
    tbl.push_back(mk(1,0,0,1,0,5'h00,16'h0000,16'hB000, 16'h0000,16'hB000,5'h11,0));
    tbl.push_back(mk(1,0,0,0,1,5'h08,16'h0000,16'h0000, 16'h0000,16'hB000,5'h08,1));
    tbl.push_back(mk(1,0,0,1,0,5'h00,16'h0000,16'h41C2, 16'h0000,16'h41C2,5'h08,0));
    tbl.push_back(mk(1,1,1,1,0,5'h00,16'h0123,16'h0000, 16'h0001,16'h0000,5'h08,1));
    tbl.push_back(mk(1,0,0,1,1,5'h01,16'h0000,16'h1000, 16'h0001,16'h1000,5'h08,1));
    tbl.push_back(mk(1,0,0,1,1,5'h01,16'h0000,16'h5000, 16'h0001,16'h5000,5'h08,1));
    tbl.push_back(mk(1,0,0,1,1,5'h02,16'h0000,16'h1000, 16'h0001,16'h1000,5'h02,0));
    tbl.push_back(mk(0,1,0,1,1,5'h1F,16'h0000,16'hABCD, 16'h0000,16'h0000,5'h00,0));

    @(negedge clock);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      check_table($sformatf("tbl%0d", i), tbl[i]);
    end

    for (int i = 0; i < 2000; i++) begin
      logic [15:0] md;
      md = 16'($urandom);
      if ($urandom_range(3) == 0) md[15:12] = 4'hC;
      else if ($urandom_range(3) == 0) md[15:12] = 4'hB;
      v = mk(($urandom_range(49) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 5'($urandom), 16'($urandom), md, '0, '0, '0, 0);
      drive(v);
      check_model($sformatf("rnd%0d", i));
    end

    // Backward branch from pc 0 wraps to the top of the address space.
    drive(mk(0,0,0,0,0,5'h00,16'h0000,16'h0000, '0,'0,'0,0));
    drive(mk(1,0,0,1,0,5'h00,16'h0000,16'hCEFE, '0,'0,'0,0));
    drive(mk(1,1,1,0,0,5'h00,16'h1234,16'h0000, '0,'0,'0,0));
    chk("bwrap.pc", pc, 16'hFFFE);
    check_model("bwrap");

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
